// File: rtl/imu_bias_filter.sv
// IMU bias filter: measures gyro bias after reset, then bias-corrects the gyro
// and IIR-filters all six axes through one time-multiplexed datapath.
module imu_bias_filter #(
  parameter int unsigned CAL_SHIFT   = 8,
  parameter int unsigned ALPHA_SHIFT = 3
) (
  input  logic               clk_50mhz,
  input  logic               reset_n,
  input  logic               recal,
  input  logic               sample_valid,
  input  logic signed [15:0] gx,
  input  logic signed [15:0] gy,
  input  logic signed [15:0] gz,
  input  logic signed [15:0] ax,
  input  logic signed [15:0] ay,
  input  logic signed [15:0] az,
  output logic signed [15:0] fgx,
  output logic signed [15:0] fgy,
  output logic signed [15:0] fgz,
  output logic signed [15:0] fax,
  output logic signed [15:0] fay,
  output logic signed [15:0] faz,
  output logic               out_valid,
  output logic               busy,
  output logic               cal_done
);

  localparam int unsigned ACC_W  = 16 + CAL_SHIFT;
  localparam int unsigned CNT_W  = CAL_SHIFT + 1;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned AXES   = 6;
  localparam int unsigned GYROS  = 3;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(1) << CAL_SHIFT;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(AXES - 1);
  localparam logic [IDX_W-1:0] IDX_OUT  = IDX_W'(AXES);

  typedef enum logic [1:0] {S_CAL, S_RUN_IDLE, S_RUN_PROC} state_t;

  state_t state_q, state_next;
  logic do_accum, do_bias, do_latch, do_step, do_output, do_abort;

  logic signed [ACC_W-1:0] acc_q  [GYROS];
  logic signed [15:0]      bias_q [GYROS];
  logic signed [15:0]      raw_q  [AXES];
  logic signed [15:0]      filt_q [AXES];
  logic [CNT_W-1:0]        cnt_q;
  logic [IDX_W-1:0]        idx_q;
  logic                    init_q;

  logic signed [15:0] raw_sel, y_sel, bias_sel, x_corr, y_next;
  logic signed [16:0] x_wide, diff, step;
  logic signed [17:0] y_sum;

  function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
    if (v > 18'sd32767)       return 16'sh7fff;
    else if (v < -18'sd32768) return 16'sh8000;
    else                      return v[15:0];
  endfunction

  // State register
  always_ff @(posedge clk_50mhz or negedge reset_n) begin
    if (!reset_n) state_q <= S_CAL;
    else          state_q <= state_next;
  end

  // Next state and datapath control; recal overrides everything
  always_comb begin
    state_next = state_q;
    do_accum   = 1'b0;
    do_bias    = 1'b0;
    do_latch   = 1'b0;
    do_step    = 1'b0;
    do_output  = 1'b0;
    do_abort   = 1'b0;
    if (recal) begin
      do_abort   = 1'b1;
      state_next = S_CAL;
    end else begin
      case (state_q)
        S_CAL: begin
          if (cnt_q == CNT_FULL) begin
            do_bias    = 1'b1;
            state_next = S_RUN_IDLE;
          end else if (sample_valid) begin
            do_accum = 1'b1;
          end
        end
        S_RUN_IDLE: begin
          if (sample_valid) begin
            do_latch   = 1'b1;
            state_next = S_RUN_PROC;
          end
        end
        S_RUN_PROC: begin
          if (idx_q == IDX_OUT) begin
            do_output  = 1'b1;
            state_next = S_RUN_IDLE;
          end else begin
            do_step = 1'b1;
          end
        end
        default: state_next = S_CAL;
      endcase
    end
  end

  // Shared subtract / IIR datapath for the axis selected by idx_q
  always_comb begin
    raw_sel  = '0;
    y_sel    = '0;
    bias_sel = '0;
    for (int k = 0; k < AXES; k++) begin
      if (idx_q == IDX_W'(k)) begin
        raw_sel = raw_q[k];
        y_sel   = filt_q[k];
      end
    end
    for (int k = 0; k < GYROS; k++) begin
      if (idx_q == IDX_W'(k)) bias_sel = bias_q[k];
    end
    x_wide = 17'(raw_sel) - 17'(bias_sel);
    x_corr = sat16(18'(x_wide));
    diff   = 17'(x_corr) - 17'(y_sel);
    step   = diff >>> ALPHA_SHIFT;
    y_sum  = 18'(y_sel) + 18'(step);
    y_next = init_q ? x_corr : sat16(y_sum);
  end

  // Calibration, sample latch, per-axis filter update and output registers
  always_ff @(posedge clk_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < GYROS; k++) begin
        acc_q[k]  <= '0;
        bias_q[k] <= '0;
      end
      for (int k = 0; k < AXES; k++) begin
        raw_q[k]  <= '0;
        filt_q[k] <= '0;
      end
      cnt_q     <= '0;
      idx_q     <= '0;
      init_q    <= 1'b1;
      fgx       <= '0;
      fgy       <= '0;
      fgz       <= '0;
      fax       <= '0;
      fay       <= '0;
      faz       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      cal_done  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (do_abort) begin
        for (int k = 0; k < GYROS; k++) begin
          acc_q[k]  <= '0;
          bias_q[k] <= '0;
        end
        cnt_q    <= '0;
        idx_q    <= '0;
        init_q   <= 1'b1;
        busy     <= 1'b0;
        cal_done <= 1'b0;
      end else begin
        if (do_accum) begin
          acc_q[0] <= acc_q[0] + ACC_W'(gx);
          acc_q[1] <= acc_q[1] + ACC_W'(gy);
          acc_q[2] <= acc_q[2] + ACC_W'(gz);
          cnt_q    <= cnt_q + CNT_W'(1);
        end
        if (do_bias) begin
          for (int k = 0; k < GYROS; k++) bias_q[k] <= 16'(acc_q[k] >>> CAL_SHIFT);
          cal_done <= 1'b1;
        end
        if (do_latch) begin
          raw_q[0] <= gx;
          raw_q[1] <= gy;
          raw_q[2] <= gz;
          raw_q[3] <= ax;
          raw_q[4] <= ay;
          raw_q[5] <= az;
          idx_q    <= '0;
          busy     <= 1'b1;
        end
        if (do_step) begin
          for (int k = 0; k < AXES; k++) begin
            if (idx_q == IDX_W'(k)) filt_q[k] <= y_next;
          end
          if (idx_q == IDX_LAST) init_q <= 1'b0;
          idx_q <= idx_q + IDX_W'(1);
        end
        if (do_output) begin
          fgx       <= filt_q[0];
          fgy       <= filt_q[1];
          fgz       <= filt_q[2];
          fax       <= filt_q[3];
          fay       <= filt_q[4];
          faz       <= filt_q[5];
          out_valid <= 1'b1;
          busy      <= 1'b0;
        end
      end
    end
  end

endmodule
